order_button_arbiter: RTL and testbench
=======================================

// Module: order_button_arbiter
// PURPOSE
// - Front-end controller for the ordering FSM (Menu/Comida/Bebida/Pago/Ordenconfirmada).
// - Synchronises and debounces the raw siguiente/regresar/cancelar buttons.
// - Arbitrates simultaneous presses and issues one-cycle, mutually exclusive command pulses.
// - Enforces a hold-off after each command; optional inactivity timeout forces a cancel.
// PARAMETERS
// DEBOUNCE_CYCLES  16      consecutive stable cycles to accept a level change (>=1)
// HOLDOFF_CYCLES   1024    cycles in HOLD after any pulse; new presses dropped (>=1)
// TIMEOUT_CYCLES   2**20   idle cycles outside Menu before forced cancel (>=2)
// PORTS
// clk            in   1  system clock, all logic on posedge
// reset          in   1  asynchronous, active-low reset
// btn_siguiente  in   1  raw button, asynchronous, active-high
// btn_regresar   in   1  raw button, asynchronous, active-high
// btn_cancelar   in   1  raw button, asynchronous, active-high
// in_menu        in   1  FSM Y0: 1 while ordering FSM is in Menu
// siguiente_p    out  1  one-cycle command pulse to FSM
// regresar_p     out  1  one-cycle command pulse to FSM
// cancelar_p     out  1  one-cycle command pulse to FSM (press or timeout)
// timeout_p      out  1  one-cycle, coincident with a timeout-caused cancelar_p
// busy           out  1  1 while in HOLD
// BEHAVIOUR
// - Reset (reset=0, async): all outputs 0, sync/debounce/timer/holdoff regs 0, state IDLE.
// - Sync: 2-FF per button. Debounce: per-button counter increments while synced!=stable,
//   clears when equal; stable toggles when count reaches DEBOUNCE_CYCLES. Event = stable 0->1.
// - Latency: pulse asserted exactly DEBOUNCE_CYCLES+3 posedges after first edge sampling raw=1.
// - Releases (1->0) produce no pulse. Glitches shorter than DEBOUNCE_CYCLES are ignored.
// - FSM, 2 states:
//   IDLE: event(s) present -> register pulse of highest priority
//         (cancelar > regresar > siguiente), others dropped; load holdoff; -> HOLD.
//   HOLD: all events dropped (not queued); count down; at 0 -> IDLE (busy=0 same cycle).
// - At most one of siguiente_p/regresar_p/cancelar_p high in any cycle; each high 1 cycle.
// - Button held across HOLD expiry: no further pulse until released and re-pressed.
// - Timer: counter width $clog2(TIMEOUT_CYCLES+1); no wrap, saturates at expiry.
// - Timer clears when in_menu=1 or any pulse issues; increments in IDLE otherwise.
// - Timer reaches TIMEOUT_CYCLES-1 in IDLE -> cancelar_p=1 and timeout_p=1, -> HOLD.
// - Same-cycle press event and timer expiry: press wins, timeout_p=0, timer clears.
// - Reset mid-HOLD or mid-debounce: everything aborts to reset values; a button still held
//   at reset release is treated as a new press (pulse after normal latency).
// CONFIGURATION
// - Macro ORDER_TIMEOUT_EN defined: inactivity timer, timeout_p as above.
// - Macro not defined: no timer logic, timeout_p tied 0, in_menu unused; press-only.
// STRUCTURE
// - Package order_pkg: state encoding (ST_IDLE, ST_HOLD), button index constants
//   (BTN_SIG=0, BTN_REG=1, BTN_CAN=2), priority order constant.
// - Sub-module button_debounce (sync + debounce + rise detect), instantiated 3x;
//   arbitration, holdoff and timer stay in this module.
// TESTING (bench params: DEBOUNCE_CYCLES=4, HOLDOFF_CYCLES=8, TIMEOUT_CYCLES=32)
// 1. btn_siguiente 0->1 held 20 cycles -> siguiente_p high 1 cycle, 7 edges after rise;
//    busy high 8 cycles; no second pulse.
// 2. btn_regresar pulse 3 cycles wide -> no output pulse ever.
// 3. All three buttons rise same cycle -> only cancelar_p, once; others never pulse.
// 4. siguiente pressed, released, regresar pressed 2 cycles after siguiente_p (in HOLD)
//    -> regresar_p never asserts; regresar pressed after busy=0 -> regresar_p asserts.
// 5. ORDER_TIMEOUT_EN, in_menu=0, no buttons -> cancelar_p+timeout_p on cycle 32 of IDLE;
//    in_menu=1 for 1 cycle at cycle 20 restarts the count.
// 6. reset low for 2 cycles mid-HOLD -> outputs 0 async, busy=0; held button after
//    release -> one pulse after 7 edges.

Source files
------------

// File: rtl/order_pkg.sv
// order_pkg: shared encodings for the order button front-end (state codes,
// button indices and the arbitration priority order).
package order_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int unsigned NUM_BTN = 3;
  localparam int unsigned BTN_SIG = 0;
  localparam int unsigned BTN_REG = 1;
  localparam int unsigned BTN_CAN = 2;

  // Highest priority first: cancelar beats regresar beats siguiente.
  localparam int unsigned PRIO_ORDER [NUM_BTN] = '{BTN_CAN, BTN_REG, BTN_SIG};

  // One-hot grant of the highest-priority asserted event; walks from the
  // lowest priority upwards so the last hit wins.
  function automatic logic [NUM_BTN-1:0] arbitrate(input logic [NUM_BTN-1:0] ev);
    logic [NUM_BTN-1:0] grant;
    grant = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (ev[PRIO_ORDER[i]]) begin
        grant = '0;
        grant[PRIO_ORDER[i]] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-FF synchroniser, stability counter and rising-edge
// detector for one raw push button. rise is high for one cycle when the
// debounced level goes 0->1; releases produce nothing.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          stable_q;
  logic          stable_d1_q;
  logic [CW-1:0] cnt_q;

  // Bring the asynchronous button into the clk domain.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], btn};
  end

  // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (sync_q[1] == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
      stable_q <= sync_q[1];
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stable_d1_q <= 1'b0;
    else        stable_d1_q <= stable_q;
  end

  assign rise = stable_q & ~stable_d1_q;

endmodule

// File: rtl/order_button_arbiter.sv
// order_button_arbiter: debounces siguiente/regresar/cancelar, arbitrates
// simultaneous presses (cancelar > regresar > siguiente) into one-cycle
// exclusive command pulses, then ignores input for HOLDOFF_CYCLES.
// Optional feature macro ORDER_TIMEOUT_EN: inactivity timer outside Menu
// forces a cancelar_p together with timeout_p.
module order_button_arbiter
  import order_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLDOFF_CYCLES  = 1024,
  parameter int unsigned TIMEOUT_CYCLES  = 2**20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_siguiente,
  input  logic btn_regresar,
  input  logic btn_cancelar,
  input  logic in_menu,
  output logic siguiente_p,
  output logic regresar_p,
  output logic cancelar_p,
  output logic timeout_p,
  output logic busy
);

  localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 1);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] ev;
  logic [NUM_BTN-1:0] pulse_d, pulse_q;
  state_t             state_q, state_d;
  logic [HW-1:0]      hold_q, hold_d;

  assign raw[BTN_SIG] = btn_siguiente;
  assign raw[BTN_REG] = btn_regresar;
  assign raw[BTN_CAN] = btn_cancelar;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .btn  (raw[g]),
      .rise (ev[g])
    );
  end

`ifdef ORDER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] timer_q;
  logic          expire;
  logic          tmo_d, tmo_q;

  assign expire = (state_q == ST_IDLE) && !in_menu && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // Idle timer: cleared in Menu or on any pulse, counts only in IDLE, saturates at expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else if (in_menu || (|pulse_d)) begin
      timer_q <= '0;
    end else if ((state_q == ST_IDLE) && (timer_q != TW'(TIMEOUT_CYCLES - 1))) begin
      timer_q <= timer_q + TW'(1);
    end
  end

  // Register the timeout flag alongside the cancel pulse it accompanies.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_q <= 1'b0;
    else        tmo_q <= tmo_d;
  end

  assign timeout_p = tmo_q;
`else
  logic unused_cfg;
  assign unused_cfg = in_menu | (TIMEOUT_CYCLES == 32'd0);
  assign timeout_p  = 1'b0;
`endif

  // Next-state, holdoff count and pulse selection.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pulse_d = '0;
`ifdef ORDER_TIMEOUT_EN
    tmo_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|ev) begin
          pulse_d = arbitrate(ev);
          hold_d  = HW'(HOLDOFF_CYCLES);
          state_d = ST_HOLD;
        end
`ifdef ORDER_TIMEOUT_EN
        else if (expire) begin
          pulse_d[BTN_CAN] = 1'b1;
          tmo_d            = 1'b1;
          hold_d           = HW'(HOLDOFF_CYCLES);
          state_d          = ST_HOLD;
        end
`endif
      end
      ST_HOLD: begin
        // Events arriving here are dropped, not queued.
        if (hold_q <= HW'(1)) begin
          hold_d  = '0;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, holdoff counter and registered command pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      pulse_q <= pulse_d;
    end
  end

  assign siguiente_p = pulse_q[BTN_SIG];
  assign regresar_p  = pulse_q[BTN_REG];
  assign cancelar_p  = pulse_q[BTN_CAN];
  assign busy        = (state_q == ST_HOLD);

endmodule

// File: tb/tb_order_button_arbiter.sv
// tb_order_button_arbiter: directed tests with DEBOUNCE=4, HOLDOFF=8, TIMEOUT=32.
// Inputs change on the falling edge; a press driven there is first sampled on
// the next rising edge, so its pulse is seen on the 8th falling edge after.
module tb_order_button_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_siguiente = 1'b0;
  logic btn_regresar = 1'b0;
  logic btn_cancelar = 1'b0;
  logic in_menu = 1'b1;
  logic siguiente_p, regresar_p, cancelar_p, timeout_p, busy;

  int tests_run = 0;
  int tests_failed = 0;

  // Results of the most recent observation window.
  int n_sig, n_reg, n_can, n_tmo, n_busy;
  int f_sig, f_reg, f_can, f_tmo, f_busy, l_busy;
  int n_multi, n_long;

  order_button_arbiter #(
    .DEBOUNCE_CYCLES(4),
    .HOLDOFF_CYCLES (8),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_siguiente(btn_siguiente),
    .btn_regresar (btn_regresar),
    .btn_cancelar (btn_cancelar),
    .in_menu      (in_menu),
    .siguiente_p  (siguiente_p),
    .regresar_p   (regresar_p),
    .cancelar_p   (cancelar_p),
    .timeout_p    (timeout_p),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
    $fatal(1);
  end

  // Advance n falling edges, tallying pulses (first index is 1-based, 0 = never).
  task automatic watch(input int n);
    logic any, prev_any;
    n_sig = 0; n_reg = 0; n_can = 0; n_tmo = 0; n_busy = 0;
    f_sig = 0; f_reg = 0; f_can = 0; f_tmo = 0; f_busy = 0; l_busy = 0;
    n_multi = 0; n_long = 0; prev_any = 1'b0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (siguiente_p) begin n_sig++; if (f_sig == 0) f_sig = i; end
      if (regresar_p)  begin n_reg++; if (f_reg == 0) f_reg = i; end
      if (cancelar_p)  begin n_can++; if (f_can == 0) f_can = i; end
      if (timeout_p)   begin n_tmo++; if (f_tmo == 0) f_tmo = i; end
      if (busy)        begin n_busy++; if (f_busy == 0) f_busy = i; l_busy = i; end
      if ((int'(siguiente_p) + int'(regresar_p) + int'(cancelar_p)) > 1) n_multi++;
      any = siguiente_p | regresar_p | cancelar_p;
      if (any && prev_any) n_long++;
      prev_any = any;
    end
  endtask

  task automatic test_reset();
    #1;
    tests_run++; if ({siguiente_p, regresar_p, cancelar_p, timeout_p, busy} !== 5'b0) begin tests_failed++; $display("FAIL reset_outputs: got %b expected 00000", {siguiente_p, regresar_p, cancelar_p, timeout_p, busy}); end
    repeat (3) @(negedge clk);
    tests_run++; if ({siguiente_p, regresar_p, cancelar_p, timeout_p, busy} !== 5'b0) begin tests_failed++; $display("FAIL reset_held: got %b expected 00000", {siguiente_p, regresar_p, cancelar_p, timeout_p, busy}); end
    reset = 1'b1;
    watch(10);
    tests_run++; if (n_sig + n_reg + n_can + n_tmo + n_busy !== 0) begin tests_failed++; $display("FAIL reset_quiet: got %0d active cycles expected 0", n_sig + n_reg + n_can + n_tmo + n_busy); end
  endtask

  task automatic test_single_press();
    btn_siguiente = 1'b1;
    watch(20);
    tests_run++; if (n_sig !== 1) begin tests_failed++; $display("FAIL sig_count: got %0d expected 1", n_sig); end
    tests_run++; if (f_sig !== 8) begin tests_failed++; $display("FAIL sig_latency: got %0d expected 8", f_sig); end
    tests_run++; if (n_busy !== 8) begin tests_failed++; $display("FAIL busy_len: got %0d expected 8", n_busy); end
    tests_run++; if (f_busy !== 8 || l_busy !== 15) begin tests_failed++; $display("FAIL busy_window: got %0d..%0d expected 8..15", f_busy, l_busy); end
    tests_run++; if (n_reg + n_can + n_tmo !== 0) begin tests_failed++; $display("FAIL sig_others: got %0d expected 0", n_reg + n_can + n_tmo); end
    tests_run++; if (n_long !== 0) begin tests_failed++; $display("FAIL sig_width: got %0d long cycles expected 0", n_long); end
    btn_siguiente = 1'b0;
    watch(10);
    tests_run++; if (n_sig + n_reg + n_can !== 0) begin tests_failed++; $display("FAIL release_pulse: got %0d expected 0", n_sig + n_reg + n_can); end
  endtask

  task automatic test_glitch();
    btn_regresar = 1'b1;
    watch(3);
    btn_regresar = 1'b0;
    watch(17);
    tests_run++; if (n_reg + n_sig + n_can + n_busy !== 0) begin tests_failed++; $display("FAIL glitch: got %0d active cycles expected 0", n_reg + n_sig + n_can + n_busy); end
  endtask

  task automatic test_priority();
    btn_siguiente = 1'b1; btn_regresar = 1'b1; btn_cancelar = 1'b1;
    watch(20);
    tests_run++; if (n_can !== 1) begin tests_failed++; $display("FAIL prio_can_count: got %0d expected 1", n_can); end
    tests_run++; if (f_can !== 8) begin tests_failed++; $display("FAIL prio_can_latency: got %0d expected 8", f_can); end
    tests_run++; if (n_sig !== 0 || n_reg !== 0) begin tests_failed++; $display("FAIL prio_dropped: got sig=%0d reg=%0d expected 0 0", n_sig, n_reg); end
    tests_run++; if (n_multi !== 0) begin tests_failed++; $display("FAIL prio_exclusive: got %0d multi cycles expected 0", n_multi); end
    btn_siguiente = 1'b0; btn_regresar = 1'b0; btn_cancelar = 1'b0;
    watch(10);
    tests_run++; if (n_sig + n_reg + n_can !== 0) begin tests_failed++; $display("FAIL prio_release: got %0d expected 0", n_sig + n_reg + n_can); end
  endtask

  task automatic test_holdoff_drop();
    btn_siguiente = 1'b1;
    watch(8);
    tests_run++; if (f_sig !== 8) begin tests_failed++; $display("FAIL hold_sig_latency: got %0d expected 8", f_sig); end
    // Regresar debounces fully inside HOLD: its event lands on the last busy cycle.
    btn_siguiente = 1'b0; btn_regresar = 1'b1;
    watch(12);
    tests_run++; if (n_reg !== 0 || n_sig !== 0) begin tests_failed++; $display("FAIL hold_drop: got reg=%0d sig=%0d expected 0 0", n_reg, n_sig); end
    tests_run++; if (l_busy !== 7) begin tests_failed++; $display("FAIL hold_last_busy: got %0d expected 7", l_busy); end
    btn_regresar = 1'b0;
    watch(10);
    tests_run++; if (n_reg + n_sig + n_can !== 0) begin tests_failed++; $display("FAIL hold_release: got %0d expected 0", n_reg + n_sig + n_can); end
    btn_regresar = 1'b1;
    watch(12);
    tests_run++; if (n_reg !== 1 || f_reg !== 8) begin tests_failed++; $display("FAIL hold_repress: got count=%0d at=%0d expected 1 at 8", n_reg, f_reg); end
    btn_regresar = 1'b0;
    watch(16);
  endtask

  task automatic test_timeout();
`ifdef ORDER_TIMEOUT_EN
    in_menu = 1'b0;
    watch(40);
    tests_run++; if (n_can !== 1 || f_can !== 32) begin tests_failed++; $display("FAIL tmo_cancel: got count=%0d at=%0d expected 1 at 32", n_can, f_can); end
    tests_run++; if (n_tmo !== 1 || f_tmo !== 32) begin tests_failed++; $display("FAIL tmo_flag: got count=%0d at=%0d expected 1 at 32", n_tmo, f_tmo); end
    in_menu = 1'b1;
    watch(2);
    in_menu = 1'b0;
    watch(19);
    tests_run++; if (n_can + n_tmo !== 0) begin tests_failed++; $display("FAIL tmo_early: got %0d expected 0", n_can + n_tmo); end
    in_menu = 1'b1;
    watch(1);
    in_menu = 1'b0;
    watch(40);
    tests_run++; if (f_can !== 32 || f_tmo !== 32) begin tests_failed++; $display("FAIL tmo_restart: got can=%0d tmo=%0d expected 32 32", f_can, f_tmo); end
    in_menu = 1'b1;
    watch(2);
    // Press event arrives in the same cycle the timer expires: press wins.
    in_menu = 1'b0;
    watch(24);
    btn_siguiente = 1'b1;
    watch(16);
    tests_run++; if (n_sig !== 1 || f_sig !== 8) begin tests_failed++; $display("FAIL tmo_collide_sig: got count=%0d at=%0d expected 1 at 8", n_sig, f_sig); end
    tests_run++; if (n_can !== 0 || n_tmo !== 0) begin tests_failed++; $display("FAIL tmo_collide_flag: got can=%0d tmo=%0d expected 0 0", n_can, n_tmo); end
    btn_siguiente = 1'b0;
    in_menu = 1'b1;
    watch(10);
`else
    in_menu = 1'b0;
    watch(40);
    tests_run++; if (n_can !== 0 || n_tmo !== 0) begin tests_failed++; $display("FAIL no_timeout: got can=%0d tmo=%0d expected 0 0", n_can, n_tmo); end
    in_menu = 1'b1;
    watch(2);
`endif
  endtask

  task automatic test_reset_mid_hold();
    btn_siguiente = 1'b1;
    watch(8);
    tests_run++; if (siguiente_p !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_pulse: got %b expected 1", siguiente_p); end
    reset = 1'b0;
    #1;
    tests_run++; if ({siguiente_p, busy} !== 2'b00) begin tests_failed++; $display("FAIL rst_async: got %b expected 00", {siguiente_p, busy}); end
    repeat (2) @(negedge clk);
    tests_run++; if ({siguiente_p, regresar_p, cancelar_p, timeout_p, busy} !== 5'b0) begin tests_failed++; $display("FAIL rst_mid_hold: got %b expected 00000", {siguiente_p, regresar_p, cancelar_p, timeout_p, busy}); end
    reset = 1'b1;
    watch(20);
    tests_run++; if (n_sig !== 1 || f_sig !== 8) begin tests_failed++; $display("FAIL rst_held_press: got count=%0d at=%0d expected 1 at 8", n_sig, f_sig); end
    tests_run++; if (n_busy !== 8) begin tests_failed++; $display("FAIL rst_busy_len: got %0d expected 8", n_busy); end
    btn_siguiente = 1'b0;
    watch(10);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_priority();
    test_holdoff_drop();
    test_timeout();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
